// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and constants for the bit serializer and its detector-side peers.
// The words_sent width matches the detector's dseq_count width.
package seq_bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int WORDS_SENT_W = 16;

    // Observation bundle for checkers: FSM state plus holding-register occupancy.
    typedef struct packed {
        state_e state;
        logic   hold_full;
    } dbg_t;

endpackage

// File: rtl/seq_word_hold_reg.sv
// Single-entry holding register with a full flag. It accepts a word while the
// shifter is busy and hands it over on the shifter's last bit.
module seq_word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load and drain never coincide: loading needs word_ready, which requires the entry empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive over valid/ready;
// bits leave gaplessly, one per clk, changing on posedge.
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic                    abort,
    output logic                    ser_bit,
    output logic                    ser_valid,
    output logic                    word_done,
    output logic [WORDS_SENT_W-1:0] words_sent,
    output dbg_t                    dbg
);

    // Handshake: a word moves on a posedge where word_valid && word_ready. word_ready
    // depends only on registered state and abort, never on word_valid; word_in is
    // ignored while word_valid is low.

    localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);

    state_e                  r_state;
    logic [WIDTH-1:0]        r_shreg;
    logic [BCNT_W-1:0]       r_bcnt;
    logic [WORDS_SENT_W-1:0] r_words_sent;
    logic                    r_rdy_en;

    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_xfer;
    logic             w_last;
    logic             w_hold_load;
    logic             w_hold_drain;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    assign w_last = (r_state == ST_SHIFT) && (r_bcnt == '0);

    // r_rdy_en keeps word_ready low throughout reset and opens it at the first posedge.
    assign word_ready = r_rdy_en && !w_hold_full && !abort;
    assign w_xfer     = word_valid && word_ready;

    // A transfer at the last bit with the hold empty goes straight to the shifter.
    assign w_hold_load  = w_xfer && (r_state == ST_SHIFT) && !w_last;
    assign w_hold_drain = w_last && w_hold_full && !abort;

    assign w_head    = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};

    seq_word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_hold_load),
        .i_drain (w_hold_drain),
        .i_flush (abort),
        .i_data  (word_in),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bcnt       <= '0;
            r_words_sent <= '0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            // abort drops the in-flight word before it can be counted
            if (abort) begin
                r_state <= ST_IDLE;
                r_shreg <= '0;
                r_bcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_xfer) begin
                            r_shreg <= word_in;
                            r_bcnt  <= BCNT_LAST;
                            r_state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (r_bcnt != '0) begin
                            r_shreg <= w_shifted;
                            r_bcnt  <= r_bcnt - 1'b1;
                        end else begin
                            r_words_sent <= r_words_sent + 1'b1;
                            if (w_hold_full) begin
                                r_shreg <= w_hold_data;
                                r_bcnt  <= BCNT_LAST;
                            end else if (w_xfer) begin
                                r_shreg <= word_in;
                                r_bcnt  <= BCNT_LAST;
                            end else begin
                                r_shreg <= '0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ser_valid  = (r_state == ST_SHIFT);
    assign ser_bit    = ser_valid ? w_head : IDLE_BIT;
    assign word_done  = w_last;
    assign words_sent = r_words_sent;

    assign dbg.state     = r_state;
    assign dbg.hold_full = w_hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed scenarios plus random
// traffic, compared against a bit-queue model of the serial stream.
module tb_seq_bit_serializer;
  import seq_bit_serializer_pkg::*;

  localparam int W = 8;
  localparam bit IDLE_B = 1'b0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         abort = 1'b0;
  logic         ser_bit;
  logic         ser_valid;
  logic         word_done;
  logic [15:0]  words_sent;
  dbg_t         dbg;

  int n_vec = 0;
  int n_err = 0;

  // Model: every bit still to be driven, head = bit on ser_bit this cycle.
  logic [0:0]   exp_q[$];
  logic [15:0]  exp_sent = '0;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_B)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .abort      (abort),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .word_done  (word_done),
    .words_sent (words_sent),
    .dbg        (dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int words_held();
    return (exp_q.size() + W - 1) / W;
  endfunction

  // One clock cycle: check outputs at negedge, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] w, input logic ab);
    logic rdy;
    int   sz;
    @(negedge clk);
    sz = exp_q.size();
    check("ser_valid", 32'(ser_valid), 32'(sz > 0));
    check("ser_bit", 32'(ser_bit), (sz > 0) ? 32'(exp_q[0]) : 32'(IDLE_B));
    check("word_done", 32'(word_done), 32'((sz > 0) && (sz % W == 1)));
    check("words_sent", 32'(words_sent), 32'(exp_sent));
    check("dbg_state", 32'(logic'(dbg.state)), 32'(sz > 0));
    check("dbg_hold_full", 32'(dbg.hold_full), 32'(words_held() == 2));
    word_valid = v;
    word_in    = w;
    abort      = ab;
    #1;
    rdy = (words_held() < 2) && !ab;
    check("word_ready", 32'(word_ready), 32'(rdy));
    if (ab) begin
      exp_q.delete();
    end else begin
      if (sz > 0) begin
        if (sz % W == 1) exp_sent++;
        void'(exp_q.pop_front());
      end
      if (v && rdy)
        for (int i = 0; i < W; i++) exp_q.push_back(w[W-1-i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0);
  endtask

  task automatic check_in_reset();
    check("rst_ser_valid", 32'(ser_valid), 32'(0));
    check("rst_ser_bit", 32'(ser_bit), 32'(IDLE_B));
    check("rst_word_done", 32'(word_done), 32'(0));
    check("rst_words_sent", 32'(words_sent), 32'(0));
    check("rst_word_ready", 32'(word_ready), 32'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    word_valid = 1'b0;
    abort      = 1'b0;
    reset      = 1'b1;
    exp_q.delete();
    exp_sent = '0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(word_ready), 32'(1));
  endtask

  initial begin
    #2;
    check_in_reset();
    repeat (2) @(posedge clk);
    release_reset();

    // Single word 0xB5: bits 1,0,1,1,0,1,0,1 then idle.
    cycle(1'b1, 8'hB5, 1'b0);
    idle(9);
    check("b5_words_sent", 32'(words_sent), 32'(1));

    // Back-to-back 0x17, 0xA0; a third offer is refused while the hold is full.
    cycle(1'b1, 8'h17, 1'b0);
    cycle(1'b1, 8'hA0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    idle(16);
    check("b2b_words_sent", 32'(words_sent), 32'(3));

    // Direct load on the last bit with the hold empty.
    cycle(1'b1, 8'h0F, 1'b0);
    idle(7);
    cycle(1'b1, 8'hF0, 1'b0);
    idle(9);

    // Abort with one word shifting and one held.
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    idle(2);
    cycle(1'b0, 8'h00, 1'b1);
    idle(2);
    check("abort_words_sent", 32'(words_sent), 32'(5));
    cycle(1'b1, 8'h96, 1'b0);
    idle(9);

    // Reset mid-shift.
    cycle(1'b1, 8'h5A, 1'b0);
    idle(4);
    #2;
    reset = 1'b0;
    #1;
    check_in_reset();
    @(posedge clk);
    #1;
    check_in_reset();
    release_reset();

    // Counter wrap from 0xFFFF.
    idle(1);
    force dut.r_words_sent = 16'hFFFF;
    #1;
    release dut.r_words_sent;
    exp_sent = 16'hFFFF;
    cycle(1'b1, 8'h81, 1'b0);
    idle(9);
    check("wrap_words_sent", 32'(words_sent), 32'(0));

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 3);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
